// File: rtl/sram_sched_pkg.sv
// Shared types for the SRAM request scheduler: FSM state encoding and the
// command FIFO entry layout.
package sram_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WRITE   = 2'd1,
    ST_READ    = 2'd2,
    ST_CAPTURE = 2'd3
  } sched_state_e;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } fifo_entry_t;

endpackage

// File: rtl/sram_sched_fifo.sv
// Circular command FIFO for the SRAM scheduler. Ready is decoded from the
// registered occupancy only, so a same-cycle pop never frees a full slot early.
module sram_sched_fifo
  import sram_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t push_data_i,
  output logic        ready_o,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_s;
  logic          pop_s;

  assign ready_o = (count_q != CNT_FULL);
  assign empty_o = (count_q == CNT_ZERO);
  assign push_s  = push_i && ready_o;
  assign pop_s   = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];

  // Entry storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= CNT_ZERO;
    end else begin
      if (push_s) begin
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_req_scheduler.sv
// Queues read/write requests and replays them one at a time onto an SRAM
// controller. Optional completion counters: define SRAM_SCHED_STATS_EN.
module sram_req_scheduler
  import sram_sched_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned RD_CYCLES = 2,
  parameter int unsigned WR_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic [15:0] mem_address,
  output logic [7:0]  mem_data_in,
  output logic        mem_read_en,
  output logic        mem_write_en,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic [15:0] wr_count
);

  localparam logic [15:0] RD_LAST = 16'(RD_CYCLES - 1);
  localparam logic [15:0] WR_LAST = 16'(WR_CYCLES - 1);

  sched_state_e state_q;
  logic [15:0]  cyc_q;
  logic [15:0]  mem_address_q;
  logic [7:0]   mem_data_q;
  logic         rd_en_q;
  logic         wr_en_q;
  logic         rsp_valid_q;
  logic [7:0]   rsp_data_q;

  fifo_entry_t  push_entry_s;
  fifo_entry_t  head_s;
  logic         fifo_empty_s;
  logic         pop_s;

  assign push_entry_s = '{we: req_we, addr: req_addr, wdata: req_wdata};
  assign pop_s        = (state_q == ST_IDLE) && !fifo_empty_s;

  sram_sched_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (req_valid),
    .push_data_i(push_entry_s),
    .ready_o    (req_ready),
    .pop_i      (pop_s),
    .head_o     (head_s),
    .empty_o    (fifo_empty_s)
  );

  // Command sequencer; enables are set on the entry edge so each is high for
  // exactly its cycle budget, and returning through IDLE guarantees a gap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cyc_q         <= 16'd0;
      mem_address_q <= 16'd0;
      mem_data_q    <= 8'd0;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= 8'd0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty_s) begin
            mem_address_q <= head_s.addr;
            mem_data_q    <= head_s.wdata;
            if (head_s.we) begin
              state_q <= ST_WRITE;
              wr_en_q <= 1'b1;
              cyc_q   <= WR_LAST;
            end else begin
              state_q <= ST_READ;
              rd_en_q <= 1'b1;
              cyc_q   <= RD_LAST;
            end
          end
        end
        ST_WRITE: begin
          if (cyc_q == 16'd0) begin
            wr_en_q <= 1'b0;
            state_q <= ST_IDLE;
          end else begin
            cyc_q <= cyc_q - 16'd1;
          end
        end
        ST_READ: begin
          if (cyc_q == 16'd0) begin
            rd_en_q <= 1'b0;
            state_q <= ST_CAPTURE;
          end else begin
            cyc_q <= cyc_q - 16'd1;
          end
        end
        ST_CAPTURE: begin
          rsp_data_q  <= mem_rdata;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_IDLE;
        end
        default: begin
          rd_en_q <= 1'b0;
          wr_en_q <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign mem_address  = mem_address_q;
  assign mem_data_in  = mem_data_q;
  assign mem_read_en  = rd_en_q;
  assign mem_write_en = wr_en_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign busy         = (state_q != ST_IDLE) || !fifo_empty_s;

`ifdef SRAM_SCHED_STATS_EN
  logic [15:0] rd_count_q;
  logic [15:0] wr_count_q;
  logic        rd_done_s;
  logic        wr_done_s;

  assign rd_done_s = (state_q == ST_CAPTURE);
  assign wr_done_s = (state_q == ST_WRITE) && (cyc_q == 16'd0);

  // Saturating completion counters, updated on the same edge as the event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_count_q <= 16'd0;
      wr_count_q <= 16'd0;
    end else begin
      if (rd_done_s && (rd_count_q != 16'hFFFF)) begin
        rd_count_q <= rd_count_q + 16'd1;
      end
      if (wr_done_s && (wr_count_q != 16'hFFFF)) begin
        wr_count_q <= wr_count_q + 16'd1;
      end
    end
  end

  assign rd_count = rd_count_q;
  assign wr_count = wr_count_q;
`else
  assign rd_count = 16'd0;
  assign wr_count = 16'd0;
`endif

endmodule

// File: tb/tb_sram_req_scheduler.sv
// Directed self-checking bench for sram_req_scheduler (default parameters).
module tb_sram_req_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic [15:0] mem_address;
  logic [7:0]  mem_data_in;
  logic        mem_read_en;
  logic        mem_write_en;
  logic [7:0]  mem_rdata;
  logic        busy;
  logic [15:0] rd_count;
  logic [15:0] wr_count;

  int checks   = 0;
  int failures = 0;

  sram_req_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_address (mem_address),
    .mem_data_in (mem_data_in),
    .mem_read_en (mem_read_en),
    .mem_write_en(mem_write_en),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .rd_count    (rd_count),
    .wr_count    (wr_count)
  );

  always #5 clk = ~clk;

  // Command issue log ({we, addr} at each enable rising), response and overlap counters.
  logic [16:0] issue_log [$];
  logic        prev_active = 1'b0;
  int          rsp_seen    = 0;
  int          overlap     = 0;

  always @(negedge clk) begin
    if (mem_read_en && mem_write_en) overlap <= overlap + 1;
    if ((mem_read_en || mem_write_en) && !prev_active)
      issue_log.push_back({mem_write_en, mem_address});
    prev_active <= mem_read_en || mem_write_en;
    if (rsp_valid) rsp_seen <= rsp_seen + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic push(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                      output int stalls);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wd;
    stalls    = 0;
    while (!req_ready && stalls < 50) begin
      step();
      stalls++;
    end
    if (!req_ready) chk("push_timeout", 32'(req_ready), 32'd1);
    step();
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"},  32'(req_ready),    32'd1);
    chk({pfx, "_rspv"},   32'(rsp_valid),    32'd0);
    chk({pfx, "_rspd"},   32'(rsp_data),     32'd0);
    chk({pfx, "_addr"},   32'(mem_address),  32'd0);
    chk({pfx, "_wdata"},  32'(mem_data_in),  32'd0);
    chk({pfx, "_rd_en"},  32'(mem_read_en),  32'd0);
    chk({pfx, "_wr_en"},  32'(mem_write_en), 32'd0);
    chk({pfx, "_busy"},   32'(busy),         32'd0);
    chk({pfx, "_rd_cnt"}, 32'(rd_count),     32'd0);
    chk({pfx, "_wr_cnt"}, 32'(wr_count),     32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int          st;
    int          base;
    int          r0;
    logic [16:0] exp_log [6];
    logic [31:0] exp_wr;
    logic [31:0] exp_rd;

    rst       = 1'b1;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = 16'h0000;
    req_wdata = 8'h00;
    mem_rdata = 8'h00;
    step();
    step();
    chk_reset_vals("reset");
    rst = 1'b0;
    step();

    // Single write
    r0 = rsp_seen;
    push(1'b1, 16'h1234, 8'hA5, st);
    req_valid = 1'b0;
    chk("wr_busy_queued", 32'(busy), 32'd1);
    chk("wr_en_before", 32'(mem_write_en), 32'd0);
    step();
    chk("wr_en", 32'(mem_write_en), 32'd1);
    chk("wr_addr", 32'(mem_address), 32'h1234);
    chk("wr_data", 32'(mem_data_in), 32'hA5);
    chk("wr_rd_en_low", 32'(mem_read_en), 32'd0);
    step();
    chk("wr_en_drop", 32'(mem_write_en), 32'd0);
    chk("wr_busy_done", 32'(busy), 32'd0);
    step();
    chk("wr_no_rsp", 32'(rsp_seen - r0), 32'd0);
    chk("wr_addr_hold", 32'(mem_address), 32'h1234);

    // Single read: enable for 2 cycles, response after edge 4
    mem_rdata = 8'h3C;
    r0 = rsp_seen;
    push(1'b0, 16'h0040, 8'h00, st);
    req_valid = 1'b0;
    chk("rd_en_e0", 32'(mem_read_en), 32'd0);
    step();
    chk("rd_en_e1", 32'(mem_read_en), 32'd1);
    chk("rd_addr", 32'(mem_address), 32'h0040);
    step();
    chk("rd_en_e2", 32'(mem_read_en), 32'd1);
    chk("rd_rspv_e2", 32'(rsp_valid), 32'd0);
    step();
    chk("rd_en_e3", 32'(mem_read_en), 32'd0);
    chk("rd_rspv_e3", 32'(rsp_valid), 32'd0);
    step();
    chk("rd_rspv_e4", 32'(rsp_valid), 32'd1);
    chk("rd_rspd_e4", 32'(rsp_data), 32'h3C);
    mem_rdata = 8'h00;
    step();
    chk("rd_rspv_e5", 32'(rsp_valid), 32'd0);
    chk("rd_rspd_hold", 32'(rsp_data), 32'h3C);
    chk("rd_rsp_pulses", 32'(rsp_seen - r0), 32'd1);

    // Fill the FIFO behind a read that keeps the FSM busy
    base      = issue_log.size();
    mem_rdata = 8'h5A;
    exp_log[0] = {1'b0, 16'h0100};
    push(1'b0, 16'h0100, 8'h00, st);
    for (int i = 1; i <= 4; i++) begin
      exp_log[i] = {1'b1, 16'h0200 + 16'(i)};
      push(1'b1, 16'h0200 + 16'(i), 8'(i), st);
      chk("fill_no_stall", 32'(st), 32'd0);
    end
    chk("full_ready_low", 32'(req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    exp_log[5] = {1'b1, 16'h0205};
    push(1'b1, 16'h0205, 8'h05, st);
    chk("full_stall_cycles", 32'(st), 32'd1);
    req_valid = 1'b0;
    wait_idle("fill_idle");
    chk("order_count", 32'(issue_log.size() - base), 32'd6);
    for (int i = 0; i < 6; i++) begin
      if (base + i < issue_log.size())
        chk("order_entry", 32'(issue_log[base + i]), 32'(exp_log[i]));
    end

    // Write then read to the same address back-to-back
    base = issue_log.size();
    push(1'b1, 16'h0010, 8'h77, st);
    push(1'b0, 16'h0010, 8'h00, st);
    req_valid = 1'b0;
    wait_idle("wr_rd_idle");
    chk("wr_rd_count", 32'(issue_log.size() - base), 32'd2);
    if (issue_log.size() >= base + 2) begin
      chk("wr_rd_first", 32'(issue_log[base]), 32'h10010);
      chk("wr_rd_second", 32'(issue_log[base + 1]), 32'h00010);
    end

    // Reset during a read with two entries queued
    r0 = rsp_seen;
    push(1'b0, 16'h0300, 8'h00, st);
    push(1'b1, 16'h0301, 8'h11, st);
    push(1'b1, 16'h0302, 8'h22, st);
    chk("pre_rst_rd_en", 32'(mem_read_en), 32'd1);
    chk("pre_rst_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rst       = 1'b1;
    step();
    chk_reset_vals("midrst");
    rst  = 1'b0;
    base = issue_log.size();
    repeat (8) step();
    chk("midrst_no_rsp", 32'(rsp_seen - r0), 32'd0);
    chk("midrst_dropped", 32'(issue_log.size() - base), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);

    // Three writes and two reads for the completion counters
    mem_rdata = 8'hC3;
    push(1'b1, 16'h0400, 8'h01, st);
    push(1'b1, 16'h0401, 8'h02, st);
    push(1'b0, 16'h0402, 8'h00, st);
    push(1'b1, 16'h0403, 8'h03, st);
    push(1'b0, 16'h0404, 8'h00, st);
    req_valid = 1'b0;
    wait_idle("stats_idle");
    step();
`ifdef SRAM_SCHED_STATS_EN
    exp_wr = 32'd3;
    exp_rd = 32'd2;
`else
    exp_wr = 32'd0;
    exp_rd = 32'd0;
`endif
    chk("wr_count", 32'(wr_count), exp_wr);
    chk("rd_count", 32'(rd_count), exp_rd);
    chk("last_rsp_data", 32'(rsp_data), 32'hC3);
    chk("enable_overlap", 32'(overlap), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
